// File: rtl/nec_ir_decoder.sv
// NEC infrared remote decoder: measures mark/space widths in 10 us ticks and latches validated command/address bytes.
// Optional strict address check (addr XOR ~addr == 8'hFF) enabled by defining NEC_ADDR_CHECK_EN.
module nec_ir_decoder #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       ir_in,
    output logic [7:0] Frame_Data,
    output logic [7:0] Addr_Data,
    output logic       frame_valid,
    output logic       repeat_valid
);
    localparam int DIV  = ((CLK_HZ / 100_000) > 1) ? (CLK_HZ / 100_000) : 1;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(DIV - 1);
    localparam logic [PS_W-1:0] PS_ZERO   = {PS_W{1'b0}};
    localparam logic [PS_W-1:0] PS_ONE    = PS_W'(1);
    localparam logic [10:0]     W_MAX     = 11'd2047;
    localparam logic [10:0]     W_TIMEOUT = 11'd1100;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4
    } state_t;

    logic            ir_meta_r, ir_sync_r, ir_prev_r;
    logic            edge_s, fall_s;
    logic [PS_W-1:0] ps_r;
    logic [10:0]     width_r;
    state_t          state_r, state_s;
    logic [30:0]     shift_r, shift_s;
    logic [31:0]     word_s;
    logic [5:0]      bit_cnt_r, bit_cnt_s;
    logic            have_frame_r;
    logic            load_s, rep_s;
    logic            short_ok_s, long_ok_s, cmd_ok_s, addr_ok_s;

    function automatic logic in_win(input logic [10:0] w, input logic [10:0] lo, input logic [10:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    function automatic logic byte_pair_ok(input logic [7:0] b, input logic [7:0] nb);
        return (b ^ nb) == 8'hFF;
    endfunction

    assign edge_s     = ir_sync_r ^ ir_prev_r;
    assign fall_s     = edge_s & ~ir_sync_r;
    assign short_ok_s = in_win(width_r, 11'd40, 11'd70);
    assign long_ok_s  = in_win(width_r, 11'd140, 11'd200);
    // Only 31 bits are stored; the 32nd bit completes the word combinationally at the final edge.
    assign word_s     = {long_ok_s, shift_r};
    assign cmd_ok_s   = byte_pair_ok(word_s[23:16], word_s[31:24]);
`ifdef NEC_ADDR_CHECK_EN
    assign addr_ok_s  = byte_pair_ok(word_s[7:0], word_s[15:8]);
`else
    assign addr_ok_s  = 1'b1;
`endif

    // Input synchronizer, tick prescaler and saturating level-width counter.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            ir_meta_r <= 1'b1;
            ir_sync_r <= 1'b1;
            ir_prev_r <= 1'b1;
            ps_r      <= PS_ZERO;
            width_r   <= 11'd0;
        end else begin
            ir_meta_r <= ir_in;
            ir_sync_r <= ir_meta_r;
            ir_prev_r <= ir_sync_r;
            if (edge_s) begin
                ps_r    <= PS_ZERO;
                width_r <= 11'd0;
            end else if (ps_r == PS_LAST) begin
                ps_r <= PS_ZERO;
                if (width_r != W_MAX) begin
                    width_r <= width_r + 11'd1;
                end
            end else begin
                ps_r <= ps_r + PS_ONE;
            end
        end
    end

    // Protocol state register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an edge always outranks the timeout.
    always_comb begin
        state_s = state_r;
        if (edge_s) begin
            case (state_r)
                IDLE:       state_s = fall_s ? LEAD_MARK : IDLE;
                LEAD_MARK:  state_s = in_win(width_r, 11'd800, 11'd1000) ? LEAD_SPACE : IDLE;
                LEAD_SPACE: state_s = in_win(width_r, 11'd400, 11'd500) ? BIT_MARK : IDLE;
                BIT_MARK:   state_s = short_ok_s ? BIT_SPACE : IDLE;
                BIT_SPACE: begin
                    if (short_ok_s || long_ok_s) begin
                        state_s = (bit_cnt_r == 6'd31) ? IDLE : BIT_MARK;
                    end else begin
                        state_s = IDLE;
                    end
                end
                default:    state_s = IDLE;
            endcase
        end else if ((state_r != IDLE) && (width_r >= W_TIMEOUT)) begin
            state_s = IDLE;
        end else begin
            state_s = state_r;
        end
    end

    // Datapath and output strobes derived from the current state and the edge just seen.
    always_comb begin
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        load_s    = 1'b0;
        rep_s     = 1'b0;
        if (edge_s) begin
            case (state_r)
                LEAD_SPACE: begin
                    if (in_win(width_r, 11'd400, 11'd500)) begin
                        bit_cnt_s = 6'd0;
                        shift_s   = 31'd0;
                    end else if (in_win(width_r, 11'd180, 11'd270)) begin
                        rep_s = have_frame_r;
                    end else begin
                        rep_s = 1'b0;
                    end
                end
                BIT_SPACE: begin
                    if (short_ok_s || long_ok_s) begin
                        shift_s   = word_s[31:1];
                        bit_cnt_s = bit_cnt_r + 6'd1;
                        load_s    = (bit_cnt_r == 6'd31) && cmd_ok_s && addr_ok_s;
                    end else begin
                        load_s = 1'b0;
                    end
                end
                default: begin
                    shift_s = shift_r;
                end
            endcase
        end else begin
            load_s = 1'b0;
        end
    end

    // Registered outputs and frame bookkeeping.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            shift_r      <= 31'd0;
            bit_cnt_r    <= 6'd0;
            have_frame_r <= 1'b0;
            Frame_Data   <= 8'h00;
            Addr_Data    <= 8'h00;
            frame_valid  <= 1'b0;
            repeat_valid <= 1'b0;
        end else begin
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            frame_valid  <= load_s;
            repeat_valid <= rep_s;
            if (load_s) begin
                Frame_Data   <= word_s[23:16];
                Addr_Data    <= word_s[7:0];
                have_frame_r <= 1'b1;
            end
        end
    end
endmodule

// File: doc/nec_ir_decoder.md
# nec_ir_decoder

Decodes the raw NEC-format infrared remote signal from the on-board IR receiver into a stable 8-bit command byte, `Frame_Data`. Its output feeds the miniCar action decoder directly, and that decoder holds state as long as `Frame_Data` is stable. The block measures mark and space widths in 10 µs ticks, runs a protocol state machine and validates each frame before updating the command. It also flags NEC repeat codes.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency; the prescaler divides it down to a 10 µs tick (`CLK_HZ/100_000` cycles).
- `clk_in` input 1: system clock. One clock domain only.
- `rst` input 1: reset, synchronous and active-high.
- `ir_in` input 1: raw receiver output, asynchronous. It reads low during a 38 kHz burst (a mark) and high during a space.
- `Frame_Data` output 8: last validated command byte. It holds its value between frames.
- `Addr_Data` output 8: address byte of the last validated frame.
- `frame_valid` output 1: one-cycle pulse when `Frame_Data` and `Addr_Data` take a new value.
- `repeat_valid` output 1: one-cycle pulse on a valid repeat code.

## Operation
**Input conditioning**
- `ir_in` passes through a 2-FF synchronizer, then an edge detector that compares it with the previous synchronized value.
- The prescaler and an 11-bit width counter, which counts ticks and saturates at 2047, both clear on every detected edge.
- The width sampled at an edge is the duration of the level that just ended.

**State machine** (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE)
- IDLE: a falling edge goes to LEAD_MARK.
- LEAD_MARK, at the rising edge:
  - width 800–1000 ticks (9 ms nominal) goes to LEAD_SPACE.
  - any other width goes to IDLE.
- LEAD_SPACE, at the falling edge:
  - width 400–500 ticks (4.5 ms) starts a frame: clear the bit count, go to BIT_MARK.
  - width 180–270 ticks (2.25 ms) is a repeat code: pulse `repeat_valid` only if a valid frame has arrived since reset, then go to IDLE.
  - any other width goes to IDLE.
- BIT_MARK, at the rising edge: width 40–70 ticks (560 µs) goes to BIT_SPACE; any other width goes to IDLE.
- BIT_SPACE, at the falling edge:
  - width 40–70 ticks shifts in 0; width 140–200 ticks (1.69 ms) shifts in 1; any other width goes to IDLE.
  - Bits arrive LSB first into a 32-bit shift register: addr, ~addr, cmd, ~cmd.
  - After bits 1–31: return to BIT_MARK.
  - After bit 32: validate the frame, then go to IDLE.
- Timeout: in any state other than IDLE, a width count of 1100 ticks with no edge forces IDLE.
- The stop burst after bit 32 enters LEAD_MARK, fails the width check and is discarded silently.

**Validation**
- A frame is valid when cmd XOR ~cmd equals 8'hFF; see Configuration for the address check.
- A valid frame latches `Frame_Data` and `Addr_Data` and pulses `frame_valid`.
- An invalid frame leaves both outputs unchanged and produces no pulse.
- Any aborted sequence (width out of range or timeout) leaves every output unchanged.

## Timing
- Reset values: `Frame_Data`=8'h00, `Addr_Data`=8'h00, `frame_valid`=0, `repeat_valid`=0. Reset also clears the state to IDLE, the shift register, the bit count, the have-frame flag, the prescaler and the width counter.
- Latency: the raw `ir_in` edge that ends bit 32 leads to `frame_valid` high 3 `clk_in` cycles later. The path is 2 synchronizer stages plus a registered output.
- `Frame_Data` changes in the same cycle that `frame_valid` is high, and stays stable until the next valid frame.
- Width boundaries are inclusive. The windows tolerate about ±10 µs of tick quantization and roughly ±10% remote error.
- Width counter saturation: the counter stops at 2047 and never wraps.
- Reset asserted mid-frame: the decoder is in IDLE on the next cycle and the partial frame is lost.
- Simultaneous edge and timeout: the edge takes priority and is evaluated as normal.

## Configuration
- `NEC_ADDR_CHECK_EN`
  - Defined: a frame also requires addr XOR ~addr equal to 8'hFF (strict NEC). A frame that fails the check is discarded.
  - Undefined: the second byte is ignored, and extended-NEC remotes are accepted. `Addr_Data` still reports the first byte.

## Test plan
- Reset, then an NEC frame with addr 8'h00 and cmd 8'h45 → `frame_valid` pulses once, `Frame_Data`=8'h45, `Addr_Data`=8'h00.
- A valid frame with cmd 8'h07, then a repeat code (9 ms mark + 2.25 ms space) → `repeat_valid` pulses once and `Frame_Data` stays 8'h07. A repeat code sent straight after reset → no pulse.
- A frame with cmd 8'h16 and the ~cmd byte corrupted to 8'hE8 → no `frame_valid`, and `Frame_Data` keeps its prior value.
- A frame with addr 8'h12 and ~addr 8'h34, cmd 8'h09 → accepted without the macro and rejected with `NEC_ADDR_CHECK_EN`.
- Leader mark of 7 ms, or `ir_in` held low for 12 ms → return to IDLE with no output change. A following valid frame with cmd 8'h40 then decodes to 8'h40.
- `rst` asserted at bit 20 of a frame → the frame is aborted and all outputs return to their reset values. The next full frame with cmd 8'h42 decodes correctly.
